// File: rtl/cpu_sequencer.sv
// cpu_sequencer: FETCH/DECODE/EXEC control sequencer producing datapath strobes from a latched opcode.
module cpu_sequencer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [3:0] Opcode,
  input  logic       Z,
  input  logic       C,
  output logic       LoadIR,
  output logic       IncPC,
  output logic       SelPC,
  output logic       LoadPC,
  output logic       LoadReg,
  output logic       LoadAcc,
  output logic [1:0] SelAcc,
  output logic [3:0] SelALU,
  output logic [2:0] State,
  output logic       Halted,
  output logic       Illegal,
  output logic [7:0] InstrCount
);
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    FETCH  = 3'b001,
    DECODE = 3'b010,
    EXEC   = 3'b011,
    HALTED = 3'b100
  } state_t;

  state_t state, nextState;
  logic [3:0] opLatch;
  logic zLatch, cLatch;
  logic isUndef, isHalt, isExec, isAluOp, isJmpZ, isJmpC, takeJump;

  assign isUndef = (Opcode == 4'b1001) || (Opcode == 4'b1110);
  assign isHalt  = Opcode == 4'b1111;

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= nextState;

  always_comb begin
    nextState = IDLE;
    case (state)
      IDLE:    nextState = Start ? FETCH : IDLE;
      FETCH:   nextState = DECODE;
      DECODE:  nextState = (isHalt || isUndef) ? HALTED : EXEC;
      EXEC:    nextState = FETCH;
      HALTED:  nextState = HALTED;
      default: nextState = IDLE;
    endcase
  end

  // Opcode and flags are captured only on the edge leaving DECODE, so EXEC ignores live inputs.
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      opLatch    <= 4'd0;
      zLatch     <= 1'b0;
      cLatch     <= 1'b0;
      Illegal    <= 1'b0;
      InstrCount <= 8'd0;
    end else begin
      if (state == DECODE) begin
        opLatch <= Opcode;
        zLatch  <= Z;
        cLatch  <= C;
        Illegal <= Illegal | isUndef;
      end
      if (state == EXEC) InstrCount <= InstrCount + 8'd1;
    end

  assign isExec   = state == EXEC;
  assign isAluOp  = (opLatch == 4'b0001) || (opLatch == 4'b0010) || (opLatch == 4'b0011) ||
                    (opLatch == 4'b1011) || (opLatch == 4'b1100);
  assign isJmpZ   = (opLatch == 4'b0110) || (opLatch == 4'b0111);
  assign isJmpC   = (opLatch == 4'b1000) || (opLatch == 4'b1010);
  assign takeJump = (isJmpZ && zLatch) || (isJmpC && cLatch);

  // HALT and undefined opcodes never reach EXEC, so every EXEC either jumps or advances the PC.
  always_comb begin
    LoadIR  = state == FETCH;
    LoadPC  = isExec && takeJump;
    IncPC   = isExec && !takeJump;
    SelPC   = isExec && takeJump && ((opLatch == 4'b0111) || (opLatch == 4'b1010));
    LoadReg = isExec && (opLatch == 4'b0101);
    LoadAcc = isExec && (isAluOp || (opLatch == 4'b0100) || (opLatch == 4'b1101));
    SelAcc  = (isExec && isAluOp) ? 2'b11 : (isExec && (opLatch == 4'b0100)) ? 2'b01 : 2'b00;
    SelALU  = isExec ? opLatch : (state == HALTED) ? 4'b1111 : 4'b0000;
    State   = state;
    Halted  = state == HALTED;
  end
endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; these are listed first below.
REQ-002 Port Clk: input, 1 bit, system clock; all state changes occur on its rising edge.
REQ-003 Port Reset: input, 1 bit, asynchronous active-high reset.
REQ-004 Port Start: input, 1 bit, level; begins execution from IDLE.
REQ-005 Port Opcode: input, 4 bits, instruction-register opcode field.
REQ-006 Port Z: input, 1 bit, accumulator zero flag.
REQ-007 Port C: input, 1 bit, accumulator carry flag.
REQ-008 Outputs LoadIR, IncPC, SelPC, LoadPC, LoadReg and LoadAcc SHALL each be 1-bit control strobes.
REQ-009 Output SelAcc: 2 bits, accumulator mux select.
REQ-010 Output SelALU: 4 bits, ALU operation select.
REQ-011 Output State: 3 bits, current FSM state.
REQ-012 Output Halted: 1 bit; 1 while in HALTED.
REQ-013 Output Illegal: 1 bit; sticky flag for an undefined opcode.
REQ-014 Output InstrCount: 8 bits, count of retired instructions.
REQ-015 Opcode encodings SHALL be:
- NOP=0000, ADD=0001, SUB=0010, NOR=0011
- REG_TO_ACC=0100, ACC_TO_REG=0101
- JMPZ_REG=0110, JMPZ_IMM=0111, JMPC_REG=1000, JMPC_IMM=1010
- SHFL=1011, SHFR=1100, IMM_TO_ACC=1101, HALT=1111
- Undefined: 1001 and 1110.

Function
REQ-016 The FSM states SHALL be encoded IDLE=000, FETCH=001, DECODE=010, EXEC=011, HALTED=100.
REQ-017 IDLE SHALL go to FETCH on the next edge when Start=1; otherwise it SHALL stay in IDLE.
REQ-018 FETCH SHALL assert LoadIR=1 for exactly one cycle and then go to DECODE.
REQ-019 DECODE SHALL register Opcode, Z and C into internal latches.
- HALT: next state HALTED.
- Undefined opcode: next state HALTED and Illegal is set to 1.
- Any other opcode: next state EXEC.
REQ-020 Every strobe SHALL be 0 in DECODE, and SelALU SHALL be 0000 there.
REQ-021 EXEC SHALL last exactly one cycle, decode its outputs from the latched opcode and flags only, and then go to FETCH.
REQ-022 In EXEC, ADD, SUB, NOR, SHFL and SHFR SHALL drive LoadAcc=1, SelAcc=11, SelALU=opcode and IncPC=1.
REQ-023 In EXEC, REG_TO_ACC SHALL drive LoadAcc=1, SelAcc=01 and IncPC=1.
REQ-024 In EXEC, IMM_TO_ACC SHALL drive LoadAcc=1, SelAcc=00 and IncPC=1.
REQ-025 In EXEC, ACC_TO_REG SHALL drive LoadReg=1 and IncPC=1.
REQ-026 In EXEC, NOP SHALL drive IncPC=1 only.
REQ-027 In EXEC, a JMPZ opcode SHALL use latched Z as its condition and a JMPC opcode SHALL use latched C.
- Condition=1: LoadPC=1, IncPC=0, SelPC=0 for the _REG form and 1 for the _IMM form.
- Condition=0: IncPC=1, LoadPC=0.
REQ-028 In EXEC, SelALU SHALL equal the latched opcode for every opcode.
REQ-029 LoadPC and IncPC SHALL never both be 1 in the same cycle.
REQ-030 Outputs SHALL never be X; every unused strobe or select SHALL be driven 0.
REQ-031 Each instruction SHALL take exactly 3 cycles (FETCH, DECODE, EXEC); instruction n+1 FETCH SHALL immediately follow instruction n EXEC.
REQ-032 InstrCount SHALL increment by 1 on the edge that leaves EXEC and SHALL wrap from 255 to 0.
REQ-033 A HALT or undefined opcode SHALL NOT increment InstrCount.
REQ-034 HALTED SHALL hold every strobe at 0 and SelALU at 1111; Start SHALL be ignored there; only Reset SHALL exit it.
REQ-035 Start SHALL be ignored in every state except IDLE; deasserting Start mid-program SHALL NOT stop execution.
REQ-036 Changes on Opcode, Z or C outside DECODE SHALL NOT affect outputs.

Reset
REQ-037 Reset=1 SHALL immediately, without waiting for a clock edge, force:
- state IDLE
- every strobe 0, SelAcc=00, SelALU=0000
- Halted=0, Illegal=0, InstrCount=0
- opcode and flag latches cleared.
REQ-038 Reset asserted in any state, including mid-EXEC, SHALL abort the instruction with no further strobe pulse.
REQ-039 After Reset deasserts, the block SHALL remain in IDLE until Start=1 is sampled.

Verification
REQ-040 The bench SHALL cover these directed scenarios:
- Reset, Start=1, Opcode=ADD -> State 001,010,011; LoadIR=1 in FETCH only; in EXEC LoadAcc=1, SelAcc=11, SelALU=0001; InstrCount=1.
- JMPZ_IMM with Z=1 in DECODE, then Z driven 0 during EXEC -> EXEC LoadPC=1, SelPC=1, IncPC=0; repeat with Z=0 in DECODE -> IncPC=1, LoadPC=0.
- JMPC_REG with C=1 -> LoadPC=1, SelPC=0; C=0 -> IncPC=1.
- Opcode=1111 -> HALTED, Halted=1, SelALU=1111, InstrCount unchanged, Start pulses ignored; Opcode=1001 -> HALTED with Illegal=1.
- 256 NOP instructions -> InstrCount wraps to 0; each instruction takes 3 cycles.
- Reset asserted mid-EXEC of ACC_TO_REG -> LoadReg falls to 0 asynchronously, State=000, all counters 0.
